// File: rtl/mod_n_counter_if.sv
// Control and status bundle for mod_n_counter.
// Master drives the controls; slave (the counter) drives status.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             increment;
    logic             decrement;
    logic [WIDTH-1:0] next_value;
    logic [WIDTH-1:0] counter;
    logic             at_zero;
    logic             at_max;
    logic             wrap;
    logic             load_error;

    modport master (
        output clear, load, load_value, increment, decrement,
        input  next_value, counter, at_zero, at_max, wrap, load_error
    );

    modport slave (
        input  clear, load, load_value, increment, decrement,
        output next_value, counter, at_zero, at_max, wrap, load_error
    );
endinterface

// File: rtl/mod_n_counter.sv
// WIDTH-bit up/down counter over 0..MODULUS-1 with clear, load,
// wrap/saturate mode, registered flags and a look-ahead next value.
module mod_n_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0
) (
    input logic            clock,
    input logic            reset,
    mod_n_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             at_zero_q, at_zero_d;
    logic             at_max_q, at_max_d;
    logic             wrap_q, wrap_d;
    logic             load_error_q, load_error_d;

    // Next state: clear > load > single-direction step > hold.
    always_comb begin
        counter_d    = counter_q;
        wrap_d       = 1'b0;
        load_error_d = load_error_q;
        if (bus.clear) begin
            counter_d    = ZERO;
            load_error_d = 1'b0;
        end else if (bus.load) begin
            if (bus.load_value <= MAX) begin
                counter_d = bus.load_value;
            end else begin
                counter_d    = MAX;
                load_error_d = 1'b1;
            end
        end else if (bus.increment && !bus.decrement) begin
            if (counter_q == MAX) begin
                wrap_d    = 1'b1;
                counter_d = SATURATE ? MAX : ZERO;
            end else begin
                counter_d = counter_q + ONE;
            end
        end else if (bus.decrement && !bus.increment) begin
            if (counter_q == ZERO) begin
                wrap_d    = 1'b1;
                counter_d = SATURATE ? ZERO : MAX;
            end else begin
                counter_d = counter_q - ONE;
            end
        end
        // Flags come from the next value so they line up with counter.
        at_zero_d = (counter_d == ZERO);
        at_max_d  = (counter_d == MAX);
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q    <= ZERO;
            at_zero_q    <= 1'b1;
            at_max_q     <= 1'b0;
            wrap_q       <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            at_zero_q    <= at_zero_d;
            at_max_q     <= at_max_d;
            wrap_q       <= wrap_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.next_value = counter_d;
    assign bus.counter    = counter_q;
    assign bus.at_zero    = at_zero_q;
    assign bus.at_max     = at_max_q;
    assign bus.wrap       = wrap_q;
    assign bus.load_error = load_error_q;
endmodule
